alu_iter: RTL and testbench
===========================

# alu_iter

Multi-cycle, handshaked ALU.

- Accepts one operand pair and function code per request.
- Implements add, sub, and, or, xor, slt, sll, srl and sra using the function codes in alu_funct_defines.h.
- Returns the result and flags on a response channel.
- Shifts move one bit position per cycle, so logic stays small.
- Sits between the decode/issue stage and writeback. It is also the DUT of the ALU test-vector bench, which now drives requests and consumes responses through the handshake.

## Interface

Parameters:

- N, 32, operand/result width (power of two, ≥ 8).
- SHAMT_W, $clog2(N), shift-amount width; taken from y[SHAMT_W-1:0].

Ports:

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- x  in  N  operand A.
- y  in  N  operand B / shift amount.
- funct  in  ALU_FUNCT_WIDTH  operation code (alu_funct_defines.h).
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer takes result.
- z  out  N  result.
- equal  out  1  x == y (operands as captured).
- zero  out  1  z == 0.
- overflow  out  1  signed overflow; ADD/SUB only, else 0.

## Operation

- States: IDLE, SHIFT, DONE.
- req_ready = (state == IDLE). resp_valid = (state == DONE).
- IDLE:
  - On req_valid && req_ready, capture x, y and funct, and compute equal from the captured operands.
  - Non-shift op: compute z and flags, go to DONE.
  - Shift op with shamt = 0: z = x, go to DONE.
  - Shift op with shamt > 0: load z = x and cnt = shamt, go to SHIFT.
- SHIFT: each cycle, shift z by one (sll: zero fill left; srl: zero fill right; sra: replicate z[N-1]) and decrement cnt. When cnt reaches 1 on that shift, go to DONE.
- DONE:
  - z and flags are held stable.
  - On resp_ready, go to IDLE.
  - A request is never accepted in DONE, even when the response is consumed in the same cycle.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^N.
  - overflow = operand signs agree (SUB: x and ~y) and the result sign differs.
  - SLT is signed; z = {N-1 zeros, x<y}.
  - Unknown funct: z = 0, overflow = 0, still responds.
- zero is recomputed from the final z.
- Reset (asynchronous, any time, including mid-shift):
  - state = IDLE, cnt = 0, z = 0, all flags 0.
  - The in-flight operation is discarded, and no response is issued for it.

## Timing

- Request accepted at edge k, non-shift op: resp_valid high after edge k+1 (latency 1).
- Shift with shamt s ≥ 1: resp_valid high after edge k+1+s. Worst case is N when s = N-1.
- Response held indefinitely while resp_ready = 0.
- Minimum issue interval is 2 cycles: the DONE→IDLE transition costs one cycle.
- x, y and funct are sampled only at the accept edge; later changes have no effect.
- req_ready = 0 throughout SHIFT and DONE.

## Configuration

- ALU_BARREL_SHIFT_EN
  - Defined: shifts are computed combinationally in IDLE like other ops. The SHIFT state and cnt are removed, and all ops have latency 1.
  - Undefined: the iterative one-bit-per-cycle shifter described above.
- Flag and handshake behaviour are identical in both builds.

## Test plan

- Reset and ADD:
  - Assert rst_n = 0: all outputs 0, req_ready = 0.
  - Release reset: req_ready = 1.
  - ADD x = 7, y = 5: one cycle later resp_valid = 1, z = 12, zero = 0, overflow = 0, equal = 0.
- Overflow:
  - ADD 0x7FFFFFFF + 1 → z = 0x80000000, overflow = 1.
  - SUB 0x80000000 − 1 → z = 0x7FFFFFFF, overflow = 1.
  - SUB 5 − 5 → z = 0, zero = 1, equal = 1.
- Shifts:
  - SRA x = 0x80000000, y = 4 → z = 0xF8000000, resp_valid 5 cycles after accept (1 with ALU_BARREL_SHIFT_EN).
  - SRL same operands → 0x08000000.
  - SLL x = 1, y = 31 → 0x80000000.
  - SLL y = 0 → z = x after 1 cycle.
- SLT signedness:
  - x = 0xFFFFFFFF, y = 1 → z = 1.
  - x = 1, y = 0xFFFFFFFF → z = 0.
- Backpressure:
  - Hold resp_ready = 0 for 10 cycles: z and flags remain stable, req_ready = 0.
  - A request presented during DONE is not accepted until the cycle after resp_ready.
- Reset mid-shift:
  - SLL y = 20, assert rst_n at cycle 8: outputs 0 immediately, no resp_valid.
  - The next ADD 2 + 2 returns 4.

Source files
------------

// File: rtl/alu_iter.sv
// Purpose : handshaked ALU (add/sub/and/or/xor/slt/sll/srl/sra) with result + flags.
// Latency : 1 cycle for non-shift ops; shifts take 1 + shamt cycles (1 with ALU_BARREL_SHIFT_EN).
// Backpr. : one op in flight; the result is held in DONE until resp_ready, and no request is taken meanwhile.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake; x, y, funct sampled on accept
//   resp_valid / resp_ready response handshake; z, equal, zero, overflow held while valid
// Build option:
//   ALU_BARREL_SHIFT_EN     when defined, shifts are single-cycle and the SHIFT state disappears.
// Function codes come from alu_funct_defines.h; the fallback values below apply only when
// that header has not been included ahead of this file.

`ifndef ALU_FUNCT_DEFINES_H
`define ALU_FUNCT_DEFINES_H
`define ALU_FUNCT_WIDTH 4
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`define ALU_SLT 4'd5
`define ALU_SLL 4'd6
`define ALU_SRL 4'd7
`define ALU_SRA 4'd8
`endif

module alu_iter #(
    parameter int N       = 32,
    parameter int SHAMT_W = $clog2(N)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [N-1:0]                x,
    input  logic [N-1:0]                y,
    input  logic [`ALU_FUNCT_WIDTH-1:0] funct,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [N-1:0]                z,
    output logic                        equal,
    output logic                        zero,
    output logic                        overflow
);

    localparam int FW = `ALU_FUNCT_WIDTH;
    localparam logic [FW-1:0] F_ADD = `ALU_ADD;
    localparam logic [FW-1:0] F_SUB = `ALU_SUB;
    localparam logic [FW-1:0] F_AND = `ALU_AND;
    localparam logic [FW-1:0] F_OR  = `ALU_OR;
    localparam logic [FW-1:0] F_XOR = `ALU_XOR;
    localparam logic [FW-1:0] F_SLT = `ALU_SLT;
    localparam logic [FW-1:0] F_SLL = `ALU_SLL;
    localparam logic [FW-1:0] F_SRL = `ALU_SRL;
    localparam logic [FW-1:0] F_SRA = `ALU_SRA;

`ifdef ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t               state;
    logic [SHAMT_W-1:0]   shamt;
    logic [N-1:0]         sum;
    logic [N-1:0]         diff;
    logic [N-1:0]         alu_z;
    logic                 alu_ovf;

    assign shamt = y[SHAMT_W-1:0];

    // rst_n gates req_ready so the block advertises nothing while held in reset.
    assign req_ready  = rst_n && (state == IDLE);
    assign resp_valid = (state == DONE);

    // Single-cycle datapath evaluated on the live request operands.
    always_comb begin
        sum     = x + y;
        diff    = x - y;
        alu_z   = '0;
        alu_ovf = 1'b0;
        case (funct)
            F_ADD: begin
                alu_z   = sum;
                alu_ovf = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
            end
            F_SUB: begin
                // Subtraction adds ~y, so overflow needs x and ~y to share a sign.
                alu_z   = diff;
                alu_ovf = (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]);
            end
            F_AND: alu_z = x & y;
            F_OR:  alu_z = x | y;
            F_XOR: alu_z = x ^ y;
            F_SLT: alu_z = {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
`ifdef ALU_BARREL_SHIFT_EN
            F_SLL: alu_z = x << shamt;
            F_SRL: alu_z = x >> shamt;
            F_SRA: alu_z = $unsigned($signed(x) >>> shamt);
`else
            // Only the shamt == 0 case finishes straight from IDLE; it returns x unchanged.
            F_SLL: alu_z = x;
            F_SRL: alu_z = x;
            F_SRA: alu_z = x;
`endif
            default: begin
                alu_z   = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    logic [SHAMT_W-1:0]   cnt;
    logic [FW-1:0]        op_q;
    logic [N-1:0]         step_z;
    logic                 req_is_shift;

    assign req_is_shift = (funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA);

    // One-position shift of the running result, selected by the captured op.
    always_comb begin
        step_z = z;
        case (op_q)
            F_SLL:   step_z = {z[N-2:0], 1'b0};
            F_SRL:   step_z = {1'b0, z[N-1:1]};
            F_SRA:   step_z = {z[N-1], z[N-1:1]};
            default: step_z = z;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            z        <= '0;
            equal    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            cnt      <= '0;
            op_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        equal <= (x == y);
`ifndef ALU_BARREL_SHIFT_EN
                        op_q  <= funct;
                        if (req_is_shift && (shamt != '0)) begin
                            z        <= x;
                            cnt      <= shamt;
                            zero     <= 1'b0;
                            overflow <= 1'b0;
                            state    <= SHIFT;
                        end else
`endif
                        begin
                            z        <= alu_z;
                            overflow <= alu_ovf;
                            zero     <= (alu_z == '0);
                            state    <= DONE;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    z   <= step_z;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        zero  <= (step_z == '0);
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_AND = 4'd2;
    localparam logic [3:0] F_OR  = 4'd3;
    localparam logic [3:0] F_XOR = 4'd4;
    localparam logic [3:0] F_SLT = 4'd5;
    localparam logic [3:0] F_SLL = 4'd6;
    localparam logic [3:0] F_SRL = 4'd7;
    localparam logic [3:0] F_SRA = 4'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [3:0]  funct = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] z;
    logic        equal, zero, overflow;

    alu_iter #(.N(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .x(x), .y(y), .funct(funct),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .z(z), .equal(equal), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic        eq;
        logic        zr;
        logic        ov;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   bp_mode = 0;   // 0: always ready, 1: random stalls, 2: stalled
    int   last_cons = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 3) != 0);
            default: resp_ready = 1'b0;
        endcase
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference behaviour straight from the arithmetic definitions.
    function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, r;
        int     s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = int'(b[4:0]);
        e.z = '0; e.ov = 1'b0; e.lat = 1; e.acc = 0;
        case (f)
            F_ADD: begin r = sa + sb; e.z = r[31:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            F_SUB: begin r = sa - sb; e.z = r[31:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            F_AND: e.z = a & b;
            F_OR:  e.z = a | b;
            F_XOR: e.z = a ^ b;
            F_SLT: e.z = (sa < sb) ? 32'd1 : 32'd0;
            F_SLL: e.z = a << s;
            F_SRL: e.z = a >> s;
            F_SRA: e.z = $unsigned($signed(a) >>> s);
            default: e.z = '0;
        endcase
`ifndef ALU_BARREL_SHIFT_EN
        if (f == F_SLL || f == F_SRL || f == F_SRA) e.lat = 1 + s;
`endif
        e.eq = (a == b);
        e.zr = (e.z == 32'd0);
        return e;
    endfunction

    // Monitor / scoreboard: all DUT outputs sampled on the falling edge.
    logic        prev_hold = 1'b0;
    logic        prev_vld = 1'b0;
    logic [34:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_vld  = 1'b0;
        end else begin
            if (resp_valid) check("req_ready_low_in_done", req_ready, 0);
            if (prev_hold) begin
                check("hold_valid", resp_valid, 1);
                check("hold_data", {z, equal, zero, overflow}, held);
            end
            if (resp_valid && !prev_vld) begin
                if (q.size() == 0) check("unexpected_response", 1, 0);
                else check("latency", cyc - q[0].acc, q[0].lat);
            end
            if (resp_valid && resp_ready && q.size() > 0) begin
                e = q.pop_front();
                check("z", z, e.z);
                check("flags_eq_zero_ovf", {equal, zero, overflow}, {e.eq, e.zr, e.ov});
                last_cons = cyc;
            end
            prev_hold = resp_valid && !resp_ready;
            held      = {z, equal, zero, overflow};
            prev_vld  = resp_valid;
        end
    end

    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        x = a; y = b; funct = f; req_valid = 1'b1;
        while (!req_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                check("req_ready_timeout", 0, 1);
                req_valid = 1'b0;
                return;
            end
        end
        e = model(f, a, b);
        e.acc = cyc;
        last_acc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs after accept: the DUT must not resample them.
        req_valid = 1'b0; x = $urandom; y = $urandom; funct = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  f;
        logic [31:0] a, b;

        #12;
        check("reset_z", z, 0);
        check("reset_flags", {equal, zero, overflow}, 0);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_req_ready", req_ready, 1);

        issue(F_ADD, 32'd7, 32'd5);
        issue(F_ADD, 32'h7FFF_FFFF, 32'd1);
        issue(F_SUB, 32'h8000_0000, 32'd1);
        issue(F_SUB, 32'd5, 32'd5);
        issue(F_SRA, 32'h8000_0000, 32'd4);
        issue(F_SRL, 32'h8000_0000, 32'd4);
        issue(F_SLL, 32'd1, 32'd31);
        issue(F_SLL, 32'h1234_5678, 32'd0);
        issue(F_SLT, 32'hFFFF_FFFF, 32'd1);
        issue(F_SLT, 32'd1, 32'hFFFF_FFFF);
        issue(4'd12, 32'd3, 32'd3);
        drain();

        // Backpressure: hold the response, keep the next request pending.
        bp_mode = 2;
        issue(F_SUB, 32'd9, 32'd9);
        fork
            begin
                repeat (12) @(posedge clk);
                bp_mode = 0;
            end
            issue(F_XOR, 32'hA5A5_0000, 32'h0000_5A5A);
        join
        check("accept_after_consume", last_acc, last_cons + 1);
        drain();

        // Reset in the middle of a long shift.
        issue(F_SLL, 32'd3, 32'd20);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midshift_reset_outputs", {z, equal, zero, overflow, resp_valid, req_ready}, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        issue(F_ADD, 32'd2, 32'd2);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            f = 4'($urandom_range(0, 9));
            if (f == 4'd9) f = 4'($urandom_range(9, 15));
            a = pick();
            b = ($urandom_range(0, 7) == 0) ? a : pick();
            issue(f, a, b);
        end
        bp_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
